// File: rtl/rob_pkg.sv
// ============================================================================
// Module      : rob_pkg
// Description : Shared types, field offsets and packing helpers for the
//               banked reorder buffer (rob_nbank) and its slot cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_pkg;

    // What the head row does this cycle
    typedef enum logic [1:0] {
        COM_IDLE   = 2'd0,
        COM_NORMAL = 2'd1,
        COM_FLUSH  = 2'd2
    } com_kind_e;

    // Slot layout, LSB first: brmask, prdn, prdo, exc, busy, val
    localparam int C_OFF_BRMASK = 0;

    function automatic int slot_width(input int wreg, input int wbrm);
        return 3 + 2 * wreg + wbrm;
    endfunction

    function automatic int off_prdn(input int wbrm);
        return wbrm;
    endfunction

    function automatic int off_prdo(input int wreg, input int wbrm);
        return wbrm + wreg;
    endfunction

    function automatic int off_exc(input int wreg, input int wbrm);
        return wbrm + 2 * wreg;
    endfunction

    function automatic int off_busy(input int wreg, input int wbrm);
        return wbrm + 2 * wreg + 1;
    endfunction

    function automatic int off_val(input int wreg, input int wbrm);
        return wbrm + 2 * wreg + 2;
    endfunction

    // Write-back port, LSB first: bank, row, exc, en
    function automatic int wb_width(input int wbank, input int wb);
        return 2 + wbank + wb;
    endfunction

    function automatic int wb_off_exc(input int wbank, input int wb);
        return wb + wbank;
    endfunction

    function automatic int wb_off_en(input int wbank, input int wb);
        return wb + wbank + 1;
    endfunction

    // Kill bus, LSB first: row, brbit, en
    function automatic int kill_width(input int wbrm, input int wbank);
        return 1 + wbrm + wbank;
    endfunction

    function automatic int kill_off_en(input int wbrm, input int wbank);
        return wbrm + wbank;
    endfunction

    // PC read tag: {row, bank}
    function automatic int tag_width(input int wbank, input int wb);
        return wbank + wb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_nbank_slot.sv
// ============================================================================
// Module      : rob_nbank_slot
// Description : One reorder-buffer instruction slot. Holds val/busy/exc,
//               old/new physical register and branch mask, and applies
//               dispatch write, write-back, branch kill and row clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_nbank_slot
    import rob_pkg::*;
#(
    parameter int WIDTH_REG = 7,
    parameter int WIDTH_BRM = 4
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_wr_en,
    input  logic [slot_width(WIDTH_REG, WIDTH_BRM)-1:0] i_wr_data,
    input  logic                                        i_wb_hit,
    input  logic                                        i_wb_exc,
    input  logic                                        i_kill_en,
    input  logic [WIDTH_BRM-1:0]                        i_kill_bit,
    input  logic                                        i_clr,
    output logic                                        o_val,
    output logic                                        o_busy,
    output logic                                        o_exc,
    output logic [WIDTH_REG-1:0]                        o_prdo,
    output logic [WIDTH_REG-1:0]                        o_prdn
);

    localparam int C_OFF_PRDN = off_prdn(WIDTH_BRM);
    localparam int C_OFF_PRDO = off_prdo(WIDTH_REG, WIDTH_BRM);
    localparam int C_OFF_EXC  = off_exc(WIDTH_REG, WIDTH_BRM);
    localparam int C_OFF_BUSY = off_busy(WIDTH_REG, WIDTH_BRM);
    localparam int C_OFF_VAL  = off_val(WIDTH_REG, WIDTH_BRM);

    logic                 r_val_q,    w_val_d;
    logic                 r_busy_q,   w_busy_d;
    logic                 r_exc_q,    w_exc_d;
    logic [WIDTH_REG-1:0] r_prdo_q,   w_prdo_d;
    logic [WIDTH_REG-1:0] r_prdn_q,   w_prdn_d;
    logic [WIDTH_BRM-1:0] r_brmask_q, w_brmask_d;
    logic                 w_killed;

    // A slot dies when it depends on the mispredicted branch
    assign w_killed = i_kill_en && ((r_brmask_q & i_kill_bit) != '0);

    // Next state: row clear wins, then dispatch, then kill / write-back
    always_comb begin
        w_val_d    = r_val_q;
        w_busy_d   = r_busy_q;
        w_exc_d    = r_exc_q;
        w_prdo_d   = r_prdo_q;
        w_prdn_d   = r_prdn_q;
        w_brmask_d = r_brmask_q;
        if (i_clr) begin
            w_val_d = 1'b0;
        end else if (i_wr_en) begin
            w_val_d    = i_wr_data[C_OFF_VAL];
            w_busy_d   = i_wr_data[C_OFF_BUSY];
            w_exc_d    = i_wr_data[C_OFF_EXC];
            w_prdo_d   = i_wr_data[C_OFF_PRDO +: WIDTH_REG];
            w_prdn_d   = i_wr_data[C_OFF_PRDN +: WIDTH_REG];
            w_brmask_d = i_wr_data[C_OFF_BRMASK +: WIDTH_BRM];
        end else begin
            if (w_killed) begin
                w_val_d = 1'b0;
            end
            // Write-back to an empty slot carries no meaning and is dropped
            if (i_wb_hit && r_val_q) begin
                w_busy_d = 1'b0;
                w_exc_d  = r_exc_q | i_wb_exc;
            end
        end
    end

    // Slot state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val_q    <= 1'b0;
            r_busy_q   <= 1'b0;
            r_exc_q    <= 1'b0;
            r_prdo_q   <= '0;
            r_prdn_q   <= '0;
            r_brmask_q <= '0;
        end else begin
            r_val_q    <= w_val_d;
            r_busy_q   <= w_busy_d;
            r_exc_q    <= w_exc_d;
            r_prdo_q   <= w_prdo_d;
            r_prdn_q   <= w_prdn_d;
            r_brmask_q <= w_brmask_d;
        end
    end

    assign o_val  = r_val_q;
    assign o_busy = r_busy_q;
    assign o_exc  = r_exc_q;
    assign o_prdo = r_prdo_q;
    assign o_prdn = r_prdn_q;

endmodule

`default_nettype wire

// File: rtl/rob_nbank.sv
// ============================================================================
// Module      : rob_nbank
// Description : Banked reorder buffer. Circular queue of rows, each row has
//               NBANK slots and a shared PC base. Row dispatch at tail,
//               busy clear through write-back ports, in-order row commit,
//               branch-kill tail rollback and precise exception flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_nbank
    import rob_pkg::*;
#(
    parameter int NBANK      = 4,
    parameter int WIDTH_BANK = 3,
    parameter int WIDTH_REG  = 7,
    parameter int WIDTH_BRM  = 4,
    parameter int NWB        = 4,
    parameter int NRD        = 2
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic                                                  i_dis_we,
    input  logic [31:0]                                           i_dis_pc,
    input  logic [NBANK*slot_width(WIDTH_REG, WIDTH_BRM)-1:0]     i_dis_data,
    input  logic [NWB*wb_width(WIDTH_BANK, $clog2(NBANK))-1:0]    i_wb,
    input  logic [kill_width(WIDTH_BRM, WIDTH_BANK)-1:0]          i_kill,
    input  logic [NRD*tag_width(WIDTH_BANK, $clog2(NBANK))-1:0]   i_rd_tag,
    output logic [WIDTH_BANK-1:0]                                 o_dis_tag,
    output logic                                                  o_full,
    output logic                                                  o_empty,
    output logic [NBANK-1:0]                                      o_com_en,
    output logic [NBANK*WIDTH_REG-1:0]                            o_com_prd,
    output logic [NRD*32-1:0]                                     o_pc,
    output logic [31:0]                                           o_pc_next,
    output logic                                                  o_flush,
    output logic [31:0]                                           o_flush_pc
);

    localparam int C_WB      = $clog2(NBANK);
    localparam int C_SIZE    = 1 << WIDTH_BANK;
    localparam int C_SW      = slot_width(WIDTH_REG, WIDTH_BRM);
    localparam int C_WBW     = wb_width(WIDTH_BANK, C_WB);
    localparam int C_WB_EXC  = wb_off_exc(WIDTH_BANK, C_WB);
    localparam int C_WB_EN   = wb_off_en(WIDTH_BANK, C_WB);
    localparam int C_KILL_EN = kill_off_en(WIDTH_BRM, WIDTH_BANK);
    localparam int C_TW      = tag_width(WIDTH_BANK, C_WB);
    localparam int C_PCBW    = 32 - C_WB - 2;
    localparam logic [WIDTH_BANK:0] C_FULL_CNT = (WIDTH_BANK + 1)'(C_SIZE);

    // Queue bookkeeping
    logic [WIDTH_BANK-1:0] r_head_q,  w_head_d;
    logic [WIDTH_BANK-1:0] r_tail_q,  w_tail_d;
    logic [WIDTH_BANK:0]   r_count_q, w_count_d;
    logic [C_PCBW-1:0]     r_pcbase_q [C_SIZE];

    // Slot state views
    logic                 w_val  [C_SIZE][NBANK];
    logic                 w_busy [C_SIZE][NBANK];
    logic                 w_exc  [C_SIZE][NBANK];
    logic [WIDTH_REG-1:0] w_prdo [C_SIZE][NBANK];
    logic [WIDTH_REG-1:0] w_prdn [C_SIZE][NBANK];
    logic                 w_wb_hit [C_SIZE][NBANK];
    logic                 w_wb_exc [C_SIZE][NBANK];

    // Head row
    logic [NBANK-1:0]     w_hval, w_hbusy, w_hexc, w_exc_vec;
    logic [WIDTH_REG-1:0] w_hprdo [NBANK];
    logic [WIDTH_REG-1:0] w_hprdn [NBANK];
    logic                 w_ready;
    logic [C_WB-1:0]      w_exc_idx;
    com_kind_e            w_com_kind;
    logic                 w_commit;
    logic                 w_flush;

    // Dispatch / kill control
    logic                  w_full;
    logic                  w_dis_acc;
    logic                  w_kill_en;
    logic [WIDTH_BRM-1:0]  w_kill_bit;
    logic [WIDTH_BANK-1:0] w_kill_row;
    logic [WIDTH_BANK-1:0] w_kill_tail;
    logic [WIDTH_BANK-1:0] w_row0_next;
    logic                  w_unused_pc_lsb;

    assign w_full          = (r_count_q == C_FULL_CNT);
    assign w_kill_en       = i_kill[C_KILL_EN] && !w_flush;
    assign w_kill_bit      = i_kill[WIDTH_BANK +: WIDTH_BRM];
    assign w_kill_row      = i_kill[WIDTH_BANK-1:0];
    assign w_kill_tail     = w_kill_row + 1'b1;
    assign w_dis_acc       = i_dis_we && !w_full && !w_kill_en && !w_flush;
    assign w_commit        = (w_com_kind == COM_NORMAL);
    assign w_flush         = (w_com_kind == COM_FLUSH);
    // Low PC bits are implied by the bank index and never stored
    assign w_unused_pc_lsb = ^i_dis_pc[C_WB+1:0];

    // Decode write-back ports into per-slot busy-clear / exception hits
    always_comb begin
        logic [C_WBW-1:0] v_port;
        for (int r = 0; r < C_SIZE; r++) begin
            for (int b = 0; b < NBANK; b++) begin
                w_wb_hit[r][b] = 1'b0;
                w_wb_exc[r][b] = 1'b0;
            end
        end
        for (int p = 0; p < NWB; p++) begin
            v_port = i_wb[p*C_WBW +: C_WBW];
            if (v_port[C_WB_EN]) begin
                w_wb_hit[v_port[C_WB +: WIDTH_BANK]][v_port[C_WB-1:0]] = 1'b1;
                if (v_port[C_WB_EXC]) begin
                    w_wb_exc[v_port[C_WB +: WIDTH_BANK]][v_port[C_WB-1:0]] = 1'b1;
                end
            end
        end
    end

    // Gather the head row and classify it as idle, commit or flush
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            w_hval[b]  = w_val[r_head_q][b];
            w_hbusy[b] = w_busy[r_head_q][b];
            w_hexc[b]  = w_exc[r_head_q][b];
            w_hprdo[b] = w_prdo[r_head_q][b];
            w_hprdn[b] = w_prdn[r_head_q][b];
        end
        w_exc_vec = w_hval & w_hexc;
        w_ready   = (r_count_q != '0) && ((w_hval & w_hbusy) == '0);
        w_exc_idx = '0;
        for (int b = NBANK - 1; b >= 0; b--) begin
            if (w_exc_vec[b]) begin
                w_exc_idx = C_WB'(b);
            end
        end
        if (!w_ready) begin
            w_com_kind = COM_IDLE;
        end else if (w_exc_vec != '0) begin
            w_com_kind = COM_FLUSH;
        end else begin
            w_com_kind = COM_NORMAL;
        end
    end

    // Commit strobes: on exception only slots older than the faulting one retire
    always_comb begin
        logic [WIDTH_REG-1:0] v_prd;
        o_com_en  = '0;
        o_com_prd = '0;
        for (int b = 0; b < NBANK; b++) begin
            v_prd = w_hval[b] ? w_hprdo[b] : w_hprdn[b];
            if (w_com_kind != COM_IDLE) begin
                o_com_prd[b*WIDTH_REG +: WIDTH_REG] = v_prd;
                if (w_hval[b] && (v_prd != '0) &&
                    (w_commit || (C_WB'(b) < w_exc_idx))) begin
                    o_com_en[b] = 1'b1;
                end
            end
        end
    end

    // Pointer and occupancy next state; flush beats kill beats dispatch
    always_comb begin
        w_head_d  = w_commit ? r_head_q + 1'b1 : r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        if (w_flush) begin
            w_tail_d  = r_head_q;
            w_count_d = '0;
        end else if (w_kill_en) begin
            w_tail_d  = w_kill_tail;
            w_count_d = {1'b0, w_kill_tail - w_head_d};
        end else begin
            if (w_dis_acc) begin
                w_tail_d = r_tail_q + 1'b1;
            end
            case ({w_dis_acc, w_commit})
                2'b10:   w_count_d = r_count_q + 1'b1;
                2'b01:   w_count_d = r_count_q - 1'b1;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    // Queue pointer / occupancy register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Per-row PC base, captured when the row is dispatched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < C_SIZE; r++) begin
                r_pcbase_q[r] <= '0;
            end
        end else if (w_dis_acc) begin
            r_pcbase_q[r_tail_q] <= i_dis_pc[31:C_WB+2];
        end
    end

    // Slot array
    for (genvar r = 0; r < C_SIZE; r++) begin : g_row
        logic w_row_wr;
        logic w_row_clr;
        assign w_row_wr  = w_dis_acc && (r_tail_q == WIDTH_BANK'(r));
        assign w_row_clr = w_flush || (w_commit && (r_head_q == WIDTH_BANK'(r)));
        for (genvar b = 0; b < NBANK; b++) begin : g_bank
            rob_nbank_slot #(
                .WIDTH_REG (WIDTH_REG),
                .WIDTH_BRM (WIDTH_BRM)
            ) u_slot (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_wr_en    (w_row_wr),
                .i_wr_data  (i_dis_data[b*C_SW +: C_SW]),
                .i_wb_hit   (w_wb_hit[r][b]),
                .i_wb_exc   (w_wb_exc[r][b]),
                .i_kill_en  (w_kill_en),
                .i_kill_bit (w_kill_bit),
                .i_clr      (w_row_clr),
                .o_val      (w_val[r][b]),
                .o_busy     (w_busy[r][b]),
                .o_exc      (w_exc[r][b]),
                .o_prdo     (w_prdo[r][b]),
                .o_prdn     (w_prdn[r][b])
            );
        end
    end

    // PC read ports rebuild the full PC from row base and bank index
    always_comb begin
        logic [C_TW-1:0] v_tag;
        for (int i = 0; i < NRD; i++) begin
            v_tag = i_rd_tag[i*C_TW +: C_TW];
            o_pc[i*32 +: 32] = {r_pcbase_q[v_tag[C_TW-1:C_WB]], v_tag[C_WB-1:0], 2'b00};
        end
    end

    assign w_row0_next = i_rd_tag[C_TW-1:C_WB] + 1'b1;
    assign o_pc_next   = {r_pcbase_q[w_row0_next], {(C_WB + 2){1'b0}}};

    assign o_dis_tag  = r_tail_q;
    assign o_full     = w_full;
    assign o_empty    = (r_count_q == '0);
    assign o_flush    = w_flush;
    assign o_flush_pc = w_flush ? {r_pcbase_q[r_head_q], w_exc_idx, 2'b00} : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_rob_nbank.sv
// ============================================================================
// Module      : tb_rob_nbank
// Description : Scoreboard bench for rob_nbank: stimulus pushes expected
//               commit/flush events, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_nbank;

    localparam int NBANK = 4, WIDTH_BANK = 3, WIDTH_REG = 7, WIDTH_BRM = 4, NWB = 4, NRD = 2;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_dis_we;
    logic [31:0]  i_dis_pc;
    logic [83:0]  i_dis_data;
    logic [27:0]  i_wb;
    logic [7:0]   i_kill;
    logic [9:0]   i_rd_tag;
    logic [2:0]   o_dis_tag;
    logic         o_full, o_empty, o_flush;
    logic [3:0]   o_com_en;
    logic [27:0]  o_com_prd;
    logic [63:0]  o_pc;
    logic [31:0]  o_pc_next, o_flush_pc;

    rob_nbank #(
        .NBANK(NBANK), .WIDTH_BANK(WIDTH_BANK), .WIDTH_REG(WIDTH_REG),
        .WIDTH_BRM(WIDTH_BRM), .NWB(NWB), .NRD(NRD)
    ) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dis_we(i_dis_we), .i_dis_pc(i_dis_pc),
        .i_dis_data(i_dis_data), .i_wb(i_wb), .i_kill(i_kill), .i_rd_tag(i_rd_tag),
        .o_dis_tag(o_dis_tag), .o_full(o_full), .o_empty(o_empty), .o_com_en(o_com_en),
        .o_com_prd(o_com_prd), .o_pc(o_pc), .o_pc_next(o_pc_next), .o_flush(o_flush),
        .o_flush_pc(o_flush_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]  en;
        logic [27:0] prd;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [20:0] slot(input logic [6:0] po, input logic [6:0] pn, input logic [3:0] m);
        return {1'b1, 1'b1, 1'b0, po, pn, m};
    endfunction

    // Full row: all slots valid and busy, prdo/prdn = base + bank
    function automatic logic [83:0] row4(input logic [6:0] pob, input logic [6:0] pnb, input logic [15:0] masks);
        logic [83:0] d;
        for (int b = 0; b < 4; b++) begin
            d[b*21 +: 21] = slot(7'(pob + b), 7'(pnb + b), masks[b*4 +: 4]);
        end
        return d;
    endfunction

    task automatic dispatch(input logic [31:0] pc, input logic [83:0] data);
        i_dis_we   = 1'b1;
        i_dis_pc   = pc;
        i_dis_data = data;
        step();
        i_dis_we   = 1'b0;
    endtask

    // Port b targets bank b of the given row
    task automatic wb_row(input int row, input logic [3:0] banks, input logic [3:0] excm);
        for (int b = 0; b < 4; b++) begin
            i_wb[b*7 +: 7] = {banks[b], excm[b], 3'(row), 2'(b)};
        end
        step();
        i_wb = '0;
    endtask

    task automatic expect_com(input logic [3:0] en, input logic [27:0] prd, input logic fl, input logic [31:0] fpc);
        exp_t e;
        e.en = en; e.prd = prd; e.fl = fl; e.fpc = fpc;
        exp_q.push_back(e);
    endtask

    task automatic async_reset();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_full", 64'(o_full), 64'd0);
        check("rst_mid_empty", 64'(o_empty), 64'd1);
        check("rst_mid_tag", 64'(o_dis_tag), 64'd0);
        check("rst_mid_com_en", 64'(o_com_en), 64'd0);
        #3;
        i_rst_n = 1'b1;
        step();
    endtask

    // Monitor: every presented commit/flush must match the oldest expectation
    always @(negedge i_clk) begin
        if (i_rst_n && (o_com_en != 4'd0 || o_flush)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: got com_en=0x%0h flush=%0b, expected no commit", o_com_en, o_flush);
            end else begin
                mon_e = exp_q.pop_front();
                check("com_en", 64'(o_com_en), 64'(mon_e.en));
                check("com_prd", 64'(o_com_prd), 64'(mon_e.prd));
                check("flush", 64'(o_flush), 64'(mon_e.fl));
                check("flush_pc", 64'(o_flush_pc), 64'(mon_e.fpc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_dis_we = 1'b0; i_dis_pc = '0; i_dis_data = '0;
        i_wb = '0; i_kill = '0; i_rd_tag = '0;
        #3;
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_full", 64'(o_full), 64'd0);
        check("rst_tag", 64'(o_dis_tag), 64'd0);
        check("rst_com_en", 64'(o_com_en), 64'd0);
        check("rst_com_prd", 64'(o_com_prd), 64'd0);
        check("rst_flush", 64'(o_flush), 64'd0);
        check("rst_flush_pc", 64'(o_flush_pc), 64'd0);
        #19;
        i_rst_n = 1'b1;
        step();

        // Single row, busy cleared one bank per cycle
        dispatch(32'h100, row4(7'd5, 7'h10, 16'h0));
        check("A_empty", 64'(o_empty), 64'd0);
        check("A_tag", 64'(o_dis_tag), 64'd1);
        check("A_com_en", 64'(o_com_en), 64'd0);
        i_rd_tag = {3'd0, 2'd3, 3'd0, 2'd2};
        #1;
        check("A_pc0", 64'(o_pc[31:0]), 64'h108);
        check("A_pc1", 64'(o_pc[63:32]), 64'h10C);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) expect_com(4'b1111, {7'd8, 7'd7, 7'd6, 7'd5}, 1'b0, 32'h0);
            wb_row(0, 4'(1 << b), 4'b0000);
        end
        step();
        check("A_empty_after", 64'(o_empty), 64'd1);
        check("A_com_en_after", 64'(o_com_en), 64'd0);

        // Fill from row 1 until full; tail wraps 7 -> 0 -> 1
        for (int k = 0; k < 8; k++) begin
            dispatch(32'h1000 + 32'(k * 16), row4(7'(8'h20 + 4 * k), 7'h0, 16'h0));
            if (k == 6) check("B_wrap_tag", 64'(o_dis_tag), 64'd0);
        end
        check("B_full", 64'(o_full), 64'd1);
        check("B_tag_full", 64'(o_dis_tag), 64'd1);
        dispatch(32'h9990, row4(7'h55, 7'h0, 16'h0));
        check("B_drop_full", 64'(o_full), 64'd1);
        check("B_drop_tag", 64'(o_dis_tag), 64'd1);
        i_rd_tag = {3'd0, 2'd3, 3'd1, 2'd0};
        #1;
        check("B_pc0", 64'(o_pc[31:0]), 64'h1000);
        check("B_pc1", 64'(o_pc[63:32]), 64'h107C);
        check("B_pc_next", 64'(o_pc_next), 64'h1010);
        expect_com(4'b1111, {7'h23, 7'h22, 7'h21, 7'h20}, 1'b0, 32'h0);
        wb_row(1, 4'b1111, 4'b0000);
        step();
        check("B_full_after", 64'(o_full), 64'd0);
        check("B_empty_after", 64'(o_empty), 64'd0);
        async_reset();

        // Branch kill with a same-cycle dispatch
        dispatch(32'h300, row4(7'h40, 7'h48, 16'h0000));
        dispatch(32'h310, row4(7'h50, 7'h58, 16'h2200));
        dispatch(32'h320, row4(7'h60, 7'h68, 16'h2222));
        dispatch(32'h330, row4(7'h70, 7'h78, 16'h6666));
        i_kill = {1'b1, 4'b0010, 3'd1};
        dispatch(32'h340, row4(7'h11, 7'h0, 16'h0));
        i_kill = '0;
        check("C_tag", 64'(o_dis_tag), 64'd2);
        check("C_empty", 64'(o_empty), 64'd0);
        expect_com(4'b1111, {7'h43, 7'h42, 7'h41, 7'h40}, 1'b0, 32'h0);
        wb_row(0, 4'b1111, 4'b0000);
        step();
        // Banks 2,3 of row 1 were killed: freed register falls back to prdn
        expect_com(4'b0011, {7'h5B, 7'h5A, 7'h51, 7'h50}, 1'b0, 32'h0);
        wb_row(1, 4'b0111, 4'b0100);
        step();
        check("C_empty_after", 64'(o_empty), 64'd1);
        check("C_tag_after", 64'(o_dis_tag), 64'd2);
        async_reset();

        // Exception in bank 2 of row 0
        dispatch(32'h200, row4(7'h30, 7'h0, 16'h0));
        dispatch(32'h210, row4(7'h38, 7'h0, 16'h0));
        expect_com(4'b0011, {7'h33, 7'h32, 7'h31, 7'h30}, 1'b1, 32'h208);
        wb_row(0, 4'b1111, 4'b0100);
        i_kill = {1'b1, 4'b0001, 3'd5};
        dispatch(32'h220, row4(7'h3C, 7'h0, 16'h1111));
        i_kill = '0;
        check("D_empty", 64'(o_empty), 64'd1);
        check("D_tag", 64'(o_dis_tag), 64'd0);
        check("D_flush_low", 64'(o_flush), 64'd0);

        // Dispatch and commit in the same cycle at count 3
        dispatch(32'h400, row4(7'h60, 7'h0, 16'h0));
        dispatch(32'h410, row4(7'h64, 7'h0, 16'h0));
        dispatch(32'h420, row4(7'h68, 7'h0, 16'h0));
        expect_com(4'b1111, {7'h63, 7'h62, 7'h61, 7'h60}, 1'b0, 32'h0);
        wb_row(0, 4'b1111, 4'b0000);
        i_dis_data = row4(7'h6C, 7'h0, 16'h0);
        i_dis_data[3*21 + 11 +: 7] = 7'h0;
        i_dis_we = 1'b1;
        i_dis_pc = 32'h430;
        step();
        i_dis_we = 1'b0;
        check("E_tag", 64'(o_dis_tag), 64'd4);
        check("E_empty", 64'(o_empty), 64'd0);
        check("E_full", 64'(o_full), 64'd0);
        i_rd_tag = {3'd0, 2'd0, 3'd2, 2'd1};
        #1;
        check("E_pc0", 64'(o_pc[31:0]), 64'h424);
        check("E_pc_next", 64'(o_pc_next), 64'h430);
        expect_com(4'b1111, {7'h67, 7'h66, 7'h65, 7'h64}, 1'b0, 32'h0);
        wb_row(1, 4'b1111, 4'b0000);
        expect_com(4'b1111, {7'h6B, 7'h6A, 7'h69, 7'h68}, 1'b0, 32'h0);
        wb_row(2, 4'b1111, 4'b0000);
        expect_com(4'b0111, {7'h00, 7'h6E, 7'h6D, 7'h6C}, 1'b0, 32'h0);
        wb_row(3, 4'b1111, 4'b0000);
        check("E_empty_mid", 64'(o_empty), 64'd0);
        step();
        check("E_empty_end", 64'(o_empty), 64'd1);

        repeat (3) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
